// File: rtl/pc_lut_writer.sv
// Writable 5-bit-index -> 12-bit PC-target table with a streaming load port,
// commit lock, and a swept clear. The fetch side reads combinationally.
module pc_lut_writer #(
    parameter int unsigned D  = 12,
    parameter int unsigned AW = 5,
    parameter int unsigned N  = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic          wr_auto,
    input  logic [AW-1:0] wr_addr,
    input  logic [D-1:0]  wr_data,
    input  logic          commit,
    output logic          locked,
    output logic [AW:0]   wr_count,
    output logic          wr_err,
    input  logic [AW-1:0] rd_addr,
    output logic [D-1:0]  rd_target
);

    typedef enum logic [1:0] {StLoad, StLocked, StClear} state_e;

    localparam logic [AW:0] NumEnt  = (AW+1)'(N);
    localparam logic [AW:0] LastEnt = (AW+1)'(N - 1);
    localparam logic [AW:0] One     = (AW+1)'(1);

    state_e        state_q, state_d;
    logic [AW:0]   ptr_q, ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW:0]   sweep_q, sweep_d;
    logic          err_q, err_d;
    logic [D-1:0]  mem_q [N];

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [D-1:0]  mem_wdata;
    logic [AW:0]   wr_idx;
    logic          accept;

    // Auto beats stall (not error) once the pointer has run off the end.
    assign wr_ready = (state_q == StLoad) && !clear && !(wr_auto && (ptr_q == NumEnt));
    assign accept   = wr_valid && wr_ready;
    assign wr_idx   = wr_auto ? ptr_q : {1'b0, wr_addr};

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        sweep_d   = sweep_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = wr_idx[AW-1:0];
        mem_wdata = wr_data;

        if (clear) begin
            state_d = StClear;
            ptr_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            sweep_d = '0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (accept) begin
                        if (wr_idx < NumEnt) begin
                            mem_we = 1'b1;
                            if (cnt_q != NumEnt) cnt_d = cnt_q + One;
                        end else begin
                            err_d = 1'b1;
                        end
                        if (wr_auto) ptr_d = ptr_q + One;
                    end
                    if (commit) state_d = StLocked;
                end
                StLocked: begin
                    if (wr_valid) err_d = 1'b1;
                end
                StClear: begin
                    mem_we    = 1'b1;
                    mem_waddr = sweep_q[AW-1:0];
                    mem_wdata = '0;
                    if (sweep_q == LastEnt) state_d = StLoad;
                    else                    sweep_d = sweep_q + One;
                end
                default: state_d = StLoad;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StLoad;
            ptr_q   <= '0;
            cnt_q   <= '0;
            sweep_q <= '0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < N; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sweep_q <= sweep_d;
            err_q   <= err_d;
            if (mem_we) mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign locked   = (state_q == StLocked);
    assign wr_count = cnt_q;
    assign wr_err   = err_q;

    // Read is forced to zero while the sweep is in progress.
    assign rd_target = ((state_q != StClear) && ({1'b0, rd_addr} < NumEnt)) ?
                       mem_q[rd_addr] : '0;

endmodule

// File: tb/tb_pc_lut_writer.sv
// Bench for pc_lut_writer: table-level model checked every cycle, plus directed
// literal expectations; a second instance with N=24 covers out-of-range writes.
module tb_pc_lut_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clear = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_auto = 1'b0;
    logic        commit = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [4:0]  rd_addr = '0;
    logic [11:0] wr_data = '0;

    logic        wr_ready, locked, wr_err;
    logic [5:0]  wr_count;
    logic [11:0] rd_target;
    logic        wr_ready24, locked24, wr_err24;
    logic [5:0]  wr_count24;
    logic [11:0] rd_target24;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    pc_lut_writer #(.D(12), .AW(5), .N(32)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_auto(wr_auto), .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit),
        .locked(locked), .wr_count(wr_count), .wr_err(wr_err), .rd_addr(rd_addr),
        .rd_target(rd_target)
    );

    pc_lut_writer #(.D(12), .AW(5), .N(24)) dut24 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .wr_valid(wr_valid), .wr_ready(wr_ready24),
        .wr_auto(wr_auto), .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit),
        .locked(locked24), .wr_count(wr_count24), .wr_err(wr_err24), .rd_addr(rd_addr),
        .rd_target(rd_target24)
    );

    always #5 clk = ~clk;

    // Table-level model of the N=32 instance: a clear empties the table at once and
    // then blocks access for 32 cycles.
    logic [11:0] m_mem [32];
    bit          m_locked;
    int          m_clear_left;
    int          m_ptr;
    int          m_cnt;
    bit          m_err;

    function automatic bit m_ready();
        return !m_locked && (m_clear_left == 0) && !clear && !(wr_auto && (m_ptr == 32));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_mem[i] <= '0;
            m_locked <= 1'b0; m_clear_left <= 0; m_ptr <= 0; m_cnt <= 0; m_err <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < 32; i++) m_mem[i] <= '0;
            m_locked <= 1'b0; m_clear_left <= 32; m_ptr <= 0; m_cnt <= 0; m_err <= 1'b0;
        end else if (m_clear_left > 0) begin
            m_clear_left <= m_clear_left - 1;
        end else if (m_locked) begin
            if (wr_valid) m_err <= 1'b1;
        end else begin
            if (wr_valid && m_ready()) begin
                if (wr_auto) begin
                    m_mem[m_ptr] <= wr_data;
                    m_ptr <= m_ptr + 1;
                end else begin
                    m_mem[wr_addr] <= wr_data;
                end
                if (m_cnt < 32) m_cnt <= m_cnt + 1;
            end
            if (commit) m_locked <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (check_en) begin
                check("model wr_ready", 32'(wr_ready), 32'(m_ready()));
                check("model locked", 32'(locked), 32'(m_locked));
                check("model wr_count", 32'(wr_count), 32'(m_cnt));
                check("model wr_err", 32'(wr_err), 32'(m_err));
                check("model rd_target", 32'(rd_target),
                      (m_clear_left > 0) ? 32'd0 : 32'(m_mem[rd_addr]));
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst_n = 1'b0;
        check_en = 1'b1;
        cyc();
        cyc();
        check("reset locked", 32'(locked), 32'd0);
        check("reset wr_count", 32'(wr_count), 32'd0);
        check("reset wr_err", 32'(wr_err), 32'd0);
        check("reset wr_ready", 32'(wr_ready), 32'd1);
        rst_n = 1'b1;
        cyc();

        // 1: manual beats
        wr_valid = 1'b1; wr_auto = 1'b0; wr_addr = 5'd0; wr_data = 12'd55;
        cyc();
        wr_addr = 5'd6; wr_data = 12'hE2A;
        cyc();
        wr_valid = 1'b0; rd_addr = 5'd6; #1;
        check("t1 idx6", 32'(rd_target), 32'h0000_0E2A);
        rd_addr = 5'd7; #1;
        check("t1 idx7", 32'(rd_target), 32'd0);
        rd_addr = 5'd0; #1;
        check("t1 idx0", 32'(rd_target), 32'd55);
        check("t1 wr_count", 32'(wr_count), 32'd2);
        cyc();

        // 2: 32 auto beats, then a stalled 33rd
        wr_valid = 1'b1; wr_auto = 1'b1;
        for (int i = 0; i < 32; i++) begin
            wr_data = 12'(100 + i);
            cyc();
        end
        wr_data = 12'd999; #1;
        check("t2 ready at ptr=N", 32'(wr_ready), 32'd0);
        check("t2 wr_count", 32'(wr_count), 32'd32);
        cyc();
        check("t2 stall err", 32'(wr_err), 32'd0);
        check("t2 stall count", 32'(wr_count), 32'd32);
        wr_valid = 1'b0; rd_addr = 5'd31; #1;
        check("t2 idx31", 32'(rd_target), 32'd131);
        rd_addr = 5'd0; #1;
        check("t2 idx0", 32'(rd_target), 32'd100);
        cyc();

        // 3: commit with a simultaneous manual beat
        wr_valid = 1'b1; wr_auto = 1'b0; wr_addr = 5'd3; wr_data = 12'd130; commit = 1'b1; #1;
        check("t3 ready with commit", 32'(wr_ready), 32'd1);
        cyc();
        wr_valid = 1'b0; commit = 1'b0; rd_addr = 5'd3; #1;
        check("t3 locked", 32'(locked), 32'd1);
        check("t3 idx3", 32'(rd_target), 32'd130);
        wr_valid = 1'b1; wr_data = 12'd5; #1;
        check("t3 locked ready", 32'(wr_ready), 32'd0);
        cyc();
        wr_valid = 1'b0; #1;
        check("t3 locked err", 32'(wr_err), 32'd1);
        check("t3 idx3 kept", 32'(rd_target), 32'd130);
        cyc();

        // 4: clear from LOCKED, exactly 32 sweep cycles
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        for (int k = 0; k < 32; k++) begin
            rd_addr = 5'(k); #1;
            check("t4 sweep ready", 32'(wr_ready), 32'd0);
            check("t4 sweep rd", 32'(rd_target), 32'd0);
            cyc();
        end
        check("t4 ready after", 32'(wr_ready), 32'd1);
        check("t4 locked after", 32'(locked), 32'd0);
        check("t4 count after", 32'(wr_count), 32'd0);
        check("t4 err after", 32'(wr_err), 32'd0);
        for (int k = 0; k < 32; k++) begin
            rd_addr = 5'(k); #1;
            check("t4 entry zero", 32'(rd_target), 32'd0);
            cyc();
        end

        // 5: reset in the middle of a sweep
        wr_valid = 1'b1; wr_auto = 1'b0; wr_addr = 5'd20; wr_data = 12'h123;
        cyc();
        wr_addr = 5'd5; wr_data = 12'd9;
        cyc();
        wr_valid = 1'b0; rd_addr = 5'd20; #1;
        check("t5 idx20 written", 32'(rd_target), 32'h0000_0123);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        repeat (10) cyc();
        rst_n = 1'b0; #1;
        check("t5 reset ready", 32'(wr_ready), 32'd1);
        check("t5 reset count", 32'(wr_count), 32'd0);
        cyc();
        rst_n = 1'b1; #1;
        check("t5 idx20 zero", 32'(rd_target), 32'd0);
        rd_addr = 5'd5; #1;
        check("t5 idx5 zero", 32'(rd_target), 32'd0);
        check("t5 ready", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1; wr_auto = 1'b1; wr_data = 12'd7;
        cyc();
        wr_valid = 1'b0; wr_auto = 1'b0; rd_addr = 5'd0; #1;
        check("t5 ptr restarts", 32'(rd_target), 32'd7);
        rd_addr = 5'd1; #1;
        check("t5 idx1", 32'(rd_target), 32'd0);
        check("t5 count", 32'(wr_count), 32'd1);
        cyc();

        // 6: N=24 instance, manual write out of range
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        wr_valid = 1'b1; wr_auto = 1'b0; wr_addr = 5'd30; wr_data = 12'd77; #1;
        check("t6 ready24", 32'(wr_ready24), 32'd1);
        cyc();
        wr_valid = 1'b0; rd_addr = 5'd30; #1;
        check("t6 err24", 32'(wr_err24), 32'd1);
        check("t6 count24", 32'(wr_count24), 32'd0);
        check("t6 rd24 idx30", 32'(rd_target24), 32'd0);
        check("t6 rd32 idx30", 32'(rd_target), 32'd77);
        check("t6 err32", 32'(wr_err), 32'd0);
        wr_valid = 1'b1; wr_addr = 5'd23; wr_data = 12'd5;
        cyc();
        wr_valid = 1'b0; rd_addr = 5'd23; #1;
        check("t6 rd24 idx23", 32'(rd_target24), 32'd5);
        check("t6 count24 after", 32'(wr_count24), 32'd1);
        check("t6 err24 sticky", 32'(wr_err24), 32'd1);
        cyc();

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
